word_line_adapter: RTL
======================

WORD_LINE_ADAPTER -- requirements
Module: word_line_adapter

Interface
REQ-001 SHALL have parameter ADDR_W, default 26, line-address width toward memory interface.
REQ-002 SHALL have parameter DATA_W, default 128, line width; fixed at 128, other values unsupported.
REQ-003 SHALL have parameter LINE_BASE, default 1, offset added to every line address.
REQ-004 SHALL have parameter TIMEOUT, default 1023, max cycles waiting in RD or WR.
REQ-005 SHALL have iCLK  input  1  clock, all state on rising edge.
REQ-006 SHALL have iRST_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have cpu_req  input  1  access request, sampled only in IDLE.
REQ-008 SHALL have cpu_we  input  1  1=store, 0=load.
REQ-009 SHALL have cpu_addr  input  32  byte address.
REQ-010 SHALL have cpu_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-011 SHALL have cpu_unsigned  input  1  load zero-extend when 1, sign-extend when 0.
REQ-012 SHALL have cpu_wdata  input  32  store data, LSB-aligned.
REQ-013 SHALL have cpu_rdata  output  32  load result, valid when cpu_done=1.
REQ-014 SHALL have cpu_busy  output  1  high whenever state != IDLE.
REQ-015 SHALL have cpu_done  output  1  one-cycle completion pulse.
REQ-016 SHALL have cpu_err  output  1  one-cycle pulse coincident with cpu_done on misalign/illegal/timeout.
REQ-017 SHALL have mem_addr  output  ADDR_W  line address to memory interface.
REQ-018 SHALL have mem_read  output  1  line read request.
REQ-019 SHALL have mem_write  output  1  line write request.
REQ-020 SHALL have mem_wdata  output  DATA_W  merged line for write.
REQ-021 SHALL have mem_rdata  input  DATA_W  returned line.
REQ-022 SHALL have mem_rvalid  input  1  mem_rdata valid this cycle.
REQ-023 SHALL have mem_wait  input  1  memory stall; request not taken while high.

Function
REQ-024 SHALL implement states IDLE, RD, MERGE, WR, DONE.
REQ-025 SHALL in IDLE with cpu_req=1 latch cpu_we, cpu_addr, cpu_size, cpu_unsigned, cpu_wdata; later input changes ignored until IDLE.
REQ-026 SHALL drive mem_addr = cpu_addr[29:4] + LINE_BASE (mod 2^ADDR_W) from the latched address; line 0 never issued with default LINE_BASE.
REQ-027 SHALL treat half with addr[0]=1, word with addr[1:0]!=0, or size 11 as error: no mem access, go DONE next cycle, cpu_done=cpu_err=1.
REQ-028 SHALL for legal accesses (load and store) go IDLE->RD, assert mem_read, hold until mem_rvalid=1; mem_rvalid in any other state ignored.
REQ-029 SHALL on mem_rvalid in RD capture mem_rdata into line register, deassert mem_read next cycle; load -> DONE, store -> MERGE.
REQ-030 SHALL map line little-endian: byte k = bits [8k+7:8k], k = addr[3:0] for lowest byte.
REQ-031 SHALL load-extract 1/2/4 bytes starting at byte addr[3:0], extend per cpu_unsigned, present on cpu_rdata in DONE.
REQ-032 SHALL in MERGE (1 cycle) overwrite 1/2/4 bytes from cpu_wdata[7:0]/[15:0]/[31:0] at byte addr[3:0], others unchanged, then go WR.
REQ-033 SHALL in WR drive mem_wdata = merged line, mem_write=1; leave WR on first cycle with mem_wait=0 (mem_write deasserted next cycle) -> DONE.
REQ-034 SHALL never assert mem_read and mem_write together.
REQ-035 SHALL in DONE pulse cpu_done for exactly one cycle, return to IDLE; cpu_req in DONE ignored; next acceptance earliest in following IDLE cycle.
REQ-036 SHALL count cycles in RD and WR (counter cleared on entry); at count==TIMEOUT drop request, DONE with cpu_err=1, cpu_rdata=0.
REQ-037 SHALL hold cpu_rdata at 0 except in a successful load DONE cycle.
REQ-038 SHALL latency: load done = rvalid cycle +1; store done = cycle after WR exit with mem_wait low.

Reset
REQ-039 SHALL on iRST_n=0 asynchronously enter IDLE, clear all outputs, line register, timeout counter.
REQ-040 SHALL on reset mid-operation abandon the access with no cpu_done; a late mem_rvalid after release is ignored.

Verification
REQ-041 SHALL pass: line 0x3 = 0x...8899AABB_CCDDEEFF, load byte addr 0x31 signed -> cpu_rdata 0xFFFFFFEE, mem_addr 0x4.
REQ-042 SHALL pass: store half 0xBEEF at addr 0x36 over zero line -> mem_wdata bytes 6,7 = EF,BE, rest 0, one mem_write cycle.
REQ-043 SHALL pass: load word addr 0x2 -> no mem_read, cpu_done+cpu_err next cycle, cpu_rdata 0.
REQ-044 SHALL pass: store with mem_wait high 5 cycles in WR -> mem_write held 6 cycles, cpu_done 1 cycle after wait drops.
REQ-045 SHALL pass: no mem_rvalid, TIMEOUT=15 -> mem_read drops after 15 RD cycles, cpu_err=1.
REQ-046 SHALL pass: reset asserted in RD -> outputs 0 immediately; mem_rvalid after release gives no cpu_done.

Source files
------------

// File: rtl/word_line_adapter.sv
// word_line_adapter: turns single byte/half/word CPU loads and stores into
// whole-line (128-bit) read and read-merge-write transactions on a line
// memory port. Stores are always read-modify-write so untouched bytes of the
// line are preserved. Misaligned or illegal sizes finish without touching
// memory. A cycle counter bounds time spent waiting in RD and WR.
module word_line_adapter #(
    parameter int ADDR_W    = 26,
    parameter int DATA_W    = 128,
    parameter int LINE_BASE = 1,
    parameter int TIMEOUT   = 1023
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [1:0]        cpu_size,
    input  logic              cpu_unsigned,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    input  logic              mem_wait
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_MERGE = 3'd2,
        S_WR    = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_we;
    logic [3:0]          r_off;
    logic [1:0]          r_size;
    logic                r_uns;
    logic [31:0]         r_wdata;
    logic [DATA_W-1:0]   r_line;
    logic [CNT_W-1:0]    r_cnt;
    logic [31:0]         r_rdata;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_mem_read;
    logic                r_mem_write;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic [ADDR_W-1:0]   w_mem_addr_nxt;
    logic                w_acc_err;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_timeout;
    logic [DATA_W-1:0]   w_merged;
    logic [31:0]         w_load_val;
    logic                w_unused_addr_hi;

    // Size 11 is illegal; halves need an even address, words a 4-byte aligned one.
    function automatic logic f_illegal(input logic [1:0] size, input logic [1:0] a);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = a[0];
            2'b10:   bad = (a != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Pull 1/2/4 bytes starting at byte 'off' of a little-endian line and extend.
    function automatic logic [31:0] f_extract(input logic [DATA_W-1:0] line,
                                              input logic [3:0] off,
                                              input logic [1:0] size,
                                              input logic uns);
        logic [DATA_W-1:0] sh;
        logic [31:0]       raw;
        logic [31:0]       res;
        sh  = line >> {off, 3'b000};
        raw = sh[31:0];
        case (size)
            2'b00:   res = uns ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            2'b01:   res = uns ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    // Overwrite 1/2/4 bytes of the line at byte 'off' with the low store bytes.
    function automatic logic [DATA_W-1:0] f_merge(input logic [DATA_W-1:0] line,
                                                  input logic [3:0] off,
                                                  input logic [1:0] size,
                                                  input logic [31:0] wd);
        logic [DATA_W-1:0] mask;
        logic [DATA_W-1:0] data;
        mask = '0;
        data = '0;
        case (size)
            2'b00: begin
                mask[7:0] = 8'hFF;
                data[7:0] = wd[7:0];
            end
            2'b01: begin
                mask[15:0] = 16'hFFFF;
                data[15:0] = wd[15:0];
            end
            default: begin
                mask[31:0] = 32'hFFFF_FFFF;
                data[31:0] = wd;
            end
        endcase
        mask = mask << {off, 3'b000};
        data = data << {off, 3'b000};
        return (line & ~mask) | data;
    endfunction

    // Line address wraps modulo 2^ADDR_W after adding the base offset.
    assign w_mem_addr_nxt   = ADDR_W'(cpu_addr[29:4]) + ADDR_W'(LINE_BASE);
    assign w_acc_err        = f_illegal(cpu_size, cpu_addr[1:0]);
    assign w_cnt_inc        = r_cnt + 1'b1;
    assign w_timeout        = (w_cnt_inc == CNT_W'(TIMEOUT));
    assign w_merged         = f_merge(r_line, r_off, r_size, r_wdata);
    assign w_load_val       = f_extract(mem_rdata, r_off, r_size, r_uns);
    // Top two address bits lie outside the line-address range.
    assign w_unused_addr_hi = ^cpu_addr[31:30];

    assign cpu_rdata = r_rdata;
    assign cpu_busy  = r_busy;
    assign cpu_done  = r_done;
    assign cpu_err   = r_err;
    assign mem_addr  = r_mem_addr;
    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_wdata = r_mem_wdata;

    // Access sequencer: every output is a register updated with the state.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_off       <= '0;
            r_size      <= '0;
            r_uns       <= 1'b0;
            r_wdata     <= '0;
            r_line      <= '0;
            r_cnt       <= '0;
            r_rdata     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cpu_req) begin
                        r_we    <= cpu_we;
                        r_off   <= cpu_addr[3:0];
                        r_size  <= cpu_size;
                        r_uns   <= cpu_unsigned;
                        r_wdata <= cpu_wdata;
                        r_busy  <= 1'b1;
                        if (w_acc_err) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state    <= S_RD;
                            r_mem_read <= 1'b1;
                            r_mem_addr <= w_mem_addr_nxt;
                            r_cnt      <= '0;
                        end
                    end
                end
                S_RD: begin
                    // A returning line wins over a timeout in the same cycle.
                    if (mem_rvalid) begin
                        r_line     <= mem_rdata;
                        r_mem_read <= 1'b0;
                        if (r_we) begin
                            r_state <= S_MERGE;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_rdata <= w_load_val;
                        end
                    end else if (w_timeout) begin
                        r_mem_read <= 1'b0;
                        r_state    <= S_DONE;
                        r_done     <= 1'b1;
                        r_err      <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_MERGE: begin
                    r_line      <= w_merged;
                    r_mem_wdata <= w_merged;
                    r_mem_write <= 1'b1;
                    r_cnt       <= '0;
                    r_state     <= S_WR;
                end
                S_WR: begin
                    if (!mem_wait) begin
                        r_mem_write <= 1'b0;
                        r_state     <= S_DONE;
                        r_done      <= 1'b1;
                    end else if (w_timeout) begin
                        r_mem_write <= 1'b0;
                        r_state     <= S_DONE;
                        r_done      <= 1'b1;
                        r_err       <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_rdata <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
